// File: rtl/input_buffer_pkg.sv
// Shared defaults and helpers for the input_buffer pad conditioner.
package input_buffer_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILTER_LEN_DEF  = 3;

    function automatic int cnt_width(input int filter_len);
        return $clog2(filter_len + 1);
    endfunction

endpackage

// File: rtl/input_buffer_bit.sv
// One pad bit: synchronizer chain, optional debounce counter, edge pulses.
// Debounce counter is built only when INPUT_BUFFER_GLITCH_FILTER_EN is defined.
module input_buffer_bit
    import input_buffer_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic i_osc,
    input  logic i_rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_filt,
    output logic o_rise,
    output logic o_fall
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_param
        $error("input_buffer_bit: SYNC_STAGES or FILTER_LEN out of range");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;

    always_ff @(posedge i_osc or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef INPUT_BUFFER_GLITCH_FILTER_EN
    localparam int              CW       = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_take;

    // The level is accepted on the edge the count would reach FILTER_LEN,
    // so the counter itself never holds FILTER_LEN.
    assign w_differ = (w_sync != r_filt);
    assign w_take   = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge i_osc or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            if (w_differ && !w_take) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_take) begin
                r_filt <= w_sync;
            end
            r_rise <= w_take & w_sync;
            r_fall <= w_take & ~w_sync;
        end
    end
`else
    always_ff @(posedge i_osc or posedge i_rst) begin
        if (i_rst) begin
            r_filt <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_filt <= w_sync;
            r_rise <= w_sync & ~r_filt;
            r_fall <= ~w_sync & r_filt;
        end
    end
`endif

    assign o_sync = w_sync;
    assign o_filt = r_filt;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/input_buffer.sv
// Pad input buffer: WIDTH independent synchronize/debounce/edge-detect lanes.
// Debounce is enabled by defining INPUT_BUFFER_GLITCH_FILTER_EN.
module input_buffer
    import input_buffer_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic             osc,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] O_sync,
    output logic [WIDTH-1:0] O_filt,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    assign O = I;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        input_buffer_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_bit (
            .i_osc  (osc),
            .i_rst  (rst),
            .i_d    (I[g]),
            .o_sync (O_sync[g]),
            .o_filt (O_filt[g]),
            .o_rise (rise[g]),
            .o_fall (fall[g])
        );
    end

endmodule

// File: tb/tb_input_buffer.sv
// Randomized bench for input_buffer against a sample-history reference model.
module tb_input_buffer;
    import input_buffer_pkg::*;

    localparam int W = 8;
    localparam int S = SYNC_STAGES_DEF;
    localparam int L = FILTER_LEN_DEF;
`ifdef INPUT_BUFFER_GLITCH_FILTER_EN
    localparam int LAT = S + L;
`else
    localparam int LAT = S + 1;
`endif

    logic         osc = 1'b0;
    logic         rst;
    logic [W-1:0] I;
    logic [W-1:0] O, O_sync, O_filt, rise, fall;

    int n_checks = 0;
    int n_pass   = 0;

    // q_i[k] holds the input seen at rising edge k+1 after reset release
    logic [W-1:0] q_i[$];
    logic [W-1:0] m_filt, m_rise, m_fall;

    input_buffer #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .FILTER_LEN  (L)
    ) dut (
        .osc    (osc),
        .rst    (rst),
        .I      (I),
        .O      (O),
        .O_sync (O_sync),
        .O_filt (O_filt),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 osc = ~osc;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    endtask

    // Synchronized level after edge n is the input sampled S-1 edges earlier.
    function automatic logic [W-1:0] sync_at(input int n);
        logic [W-1:0] v;
        v = '0;
        if (n >= S) v = q_i[n-S];
        return v;
    endfunction

    // A bit's accepted level flips once its synchronized value has differed
    // from the accepted level for L consecutive samples.
    task automatic model_edge();
        int           n;
        logic [W-1:0] nf, v, s;
        n  = q_i.size();
        v  = sync_at(n - 1);
`ifdef INPUT_BUFFER_GLITCH_FILTER_EN
        nf = m_filt;
        for (int b = 0; b < W; b++) begin
            bit ok;
            ok = (v[b] != m_filt[b]);
            for (int k = 1; k <= L; k++) begin
                s = sync_at(n - k);
                if (s[b] != v[b]) ok = 1'b0;
            end
            if (ok) nf[b] = v[b];
        end
`else
        nf = v;
`endif
        m_rise = nf & ~m_filt;
        m_fall = ~nf & m_filt;
        m_filt = nf;
    endtask

    task automatic step(input logic [W-1:0] nxt);
        I = nxt;
        #1;
        chk("O_comb", O, nxt);
        @(posedge osc);
        q_i.push_back(I);
        model_edge();
        #1;
        chk("O_sync", O_sync, sync_at(q_i.size()));
        chk("O_filt", O_filt, m_filt);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("rise_and_fall", rise & fall, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        I   = W'($urandom);
        #1;
        chk("rst_O_sync", O_sync, '0);
        chk("rst_O_filt", O_filt, '0);
        chk("rst_rise", rise, '0);
        chk("rst_fall", fall, '0);
        chk("rst_O_comb", O, I);
        q_i.delete();
        m_filt = '0;
        m_rise = '0;
        m_fall = '0;
        @(negedge osc);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] cur;
        rst = 1'b1;
        I   = '0;
        do_reset();
        for (int k = 0; k < 6; k++) step('0);

        // Simultaneous multi-bit rise then fall, fixed latency
        for (int k = 1; k <= LAT + 1; k++) begin
            step(8'hA5);
            chk("lat_rise", rise, (k == LAT) ? 8'hA5 : 8'h00);
            chk("lat_fall0", fall, '0);
        end
        chk("lat_filt_hi", O_filt, 8'hA5);
        for (int k = 1; k <= LAT + 1; k++) begin
            step('0);
            chk("lat_fall", fall, (k == LAT) ? 8'hA5 : 8'h00);
            chk("lat_rise0", rise, '0);
        end
        chk("lat_filt_lo", O_filt, '0);

        // Two-clock glitch on bit 0
        step(8'h01);
        step(8'h01);
        for (int k = 0; k < LAT + 2; k++) begin
            step('0);
`ifdef INPUT_BUFFER_GLITCH_FILTER_EN
            chk("glitch_filt", O_filt, '0);
            chk("glitch_rise", rise, '0);
`endif
        end

        // Asynchronous reset in mid-filter, then held-high input after release
        for (int k = 0; k < S + 2; k++) step(8'hFF);
        #2;
        do_reset();
        for (int k = 1; k <= LAT + 1; k++) begin
            step(8'hFF);
            chk("rel_rise", rise, (k == LAT) ? 8'hFF : 8'h00);
        end

        // Random toggling with runs short and long relative to the filter
        cur = 8'hFF;
        for (int c = 0; c < 800; c++) begin
            if (c == 400) begin
                #3;
                do_reset();
            end
            cur = cur ^ (W'($urandom) & W'($urandom));
            step(cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_buffer.md
INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 Parameter WIDTH, default 1: number of buffered input bits.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop count; legal range 2..4.
REQ-003 Parameter FILTER_LEN, default 3: consecutive clocks a changed level must persist before it is accepted; legal range 1..15.
REQ-004 Port osc, input, 1: single clock, the 12 MHz oscillator; all flops rising-edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port I, input, WIDTH: raw pad input.
REQ-007 Port O, output, WIDTH: unregistered buffered copy of I.
REQ-008 Port O_sync, output, WIDTH: I after the synchronizer chain.
REQ-009 Port O_filt, output, WIDTH: debounced level.
REQ-010 Port rise, output, WIDTH: one-clock pulse per bit when O_filt goes 0->1.
REQ-011 Port fall, output, WIDTH: one-clock pulse per bit when O_filt goes 1->0.

Function
REQ-012 O SHALL equal I combinationally, with zero latency, in reset and out of reset.
REQ-013 Each bit SHALL pass through SYNC_STAGES cascaded flops; O_sync SHALL be the last stage, so an I change appears on O_sync SYNC_STAGES rising edges later.
REQ-014 Each bit SHALL have a saturating counter 0..FILTER_LEN. The counter SHALL increment while O_sync differs from O_filt and clear to 0 on any clock where they are equal.
REQ-015 O_filt SHALL take the O_sync value, and the counter SHALL clear, on the edge where the counter would reach FILTER_LEN. Total I-to-O_filt latency SHALL be SYNC_STAGES+FILTER_LEN clocks.
REQ-016 A pulse on O_sync shorter than FILTER_LEN clocks SHALL NOT change O_filt and SHALL produce no rise or fall pulse.
REQ-017 rise and fall SHALL be registered and asserted in the same cycle O_filt takes its new value, for exactly one clock.
REQ-018 rise and fall SHALL never be high together on the same bit.
REQ-019 Bits SHALL be fully independent; simultaneous changes on several bits SHALL be handled per bit with no interaction.

Reset
REQ-020 While rst is high: all synchronizer flops, counters, O_sync, O_filt, rise and fall SHALL be 0; O SHALL still follow I.
REQ-021 Assertion of rst SHALL take effect immediately, independent of osc.
REQ-022 On release of rst, O_filt=0 SHALL be the starting level, so an input held at 1 yields one rise pulse SYNC_STAGES+FILTER_LEN clocks after release.
REQ-023 Reset in mid-filter SHALL discard the partial count.

Configuration
REQ-024 Macro INPUT_BUFFER_GLITCH_FILTER_EN SHALL control the debounce filter.
REQ-025 With the macro defined, the counters and filter behaviour of REQ-014..016 SHALL be built.
REQ-026 Without the macro, no counters SHALL be built. O_filt SHALL be a one-clock registered copy of O_sync, with rise and fall derived from that copy. I-to-O_filt latency SHALL be SYNC_STAGES+1 clocks.

Structure
REQ-027 Package input_buffer_pkg SHALL hold the default constants (SYNC_STAGES_DEF=2, FILTER_LEN_DEF=3) and the counter width function clog2(FILTER_LEN+1).
REQ-028 Per-bit logic (synchronizer, counter, edge pulses) SHALL be one sub-module, input_buffer_bit, instantiated WIDTH times by a generate loop.

Verification
REQ-029 Scenario: WIDTH=1, defaults, filter on. I 0->1 held at cycle 10 -> O=1 at once, O_sync=1 at cycle 12, O_filt=1 and rise=1 at cycle 15, rise=0 at cycle 16.
REQ-030 Scenario: I high for 2 clocks, filter on -> O_sync pulses for 2 clocks; O_filt stays 0; rise and fall stay 0.
REQ-031 Scenario: I held 1 to steady state, then 1->0 held -> fall=1 for one clock 5 clocks later; O_filt=0.
REQ-032 Scenario: rst asserted asynchronously between edges while the counter is at 2 -> all registered outputs go 0 at once; O tracks I; after release with I=1, rise comes 5 clocks later.
REQ-033 Scenario: macro undefined, I 0->1 -> O_filt=1 and rise=1 after 3 clocks; a 1-clock glitch is passed to O_filt.
REQ-034 Scenario: WIDTH=8, I=8'hA5 from 8'h00 -> rise=8'hA5 for one clock, fall=8'h00; then I=8'h00 -> fall=8'hA5.
